seq_detect_scheduler: RTL and testbench
=======================================

# seq_detect_scheduler

Shares one "101" overlapping Mealy detector core among NCH serial bit-stream requesters. A round-robin arbiter grants one requester per cycle. The block saves and restores each channel's 2-bit detector context, so every stream is detected independently, exactly as if it had its own detector. It sits between the serial input channels and the match-reporting/statistics logic, and reports a tagged match result plus per-channel saturating match counts.

## Interface
- NCH, 4: number of requesting channels; must be at least 2.
- CNT_W, 8: width of each per-channel match counter.
- CH_W, $clog2(NCH): width of the channel index (derived, not overridden).

- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- in_valid  input  NCH  channel i has a bit to present.
- in_bit  input  NCH  serial data bit of channel i.
- in_ready  output  NCH  one-hot grant; the bit of channel i is consumed when in_valid[i] and in_ready[i] are both high.
- clr_cnt  input  NCH  synchronous clear of match counter i.
- det_valid  output  1  registered: one bit was consumed in the previous cycle.
- det_ch  output  CH_W  registered: index of the channel consumed.
- det_match  output  1  registered: that bit completed "101" on that channel.
- match_cnt  output  NCH*CNT_W  per-channel counters; channel i occupies bits [i*CNT_W +: CNT_W].

## Operation
- **Arbiter.** A pointer ptr (CH_W bits) marks the highest-priority channel.
  - The grant goes to the first i with in_valid[i]=1, searching cyclically from ptr upward.
  - in_ready is combinational from in_valid and ptr, and is zero when no channel is valid.
  - After a grant to channel g, ptr becomes (g+1) mod NCH. With no grant, ptr holds.
- **Context.** Each channel has its own state register ctx[i] with three states:
  - S0: no prefix.
  - S1: last bit was 1.
  - S2: last two bits were 10.
- **Transitions** for the granted channel g with bit b:
  - S0: b=1 goes to S1; b=0 stays in S0.
  - S1: b=1 stays in S1; b=0 goes to S2.
  - S2: b=1 goes to S1 and signals a match; b=0 goes to S0.
  - Only ctx[g] updates. All other contexts hold.
- **Match** is asserted only in state S2 with b=1. Overlap is allowed: after 1,0,1, the sequence 0,1 produces a second match.
- **Result register.** On each transfer: det_valid<=1, det_ch<=g, det_match<=match. With no transfer, det_valid<=0, det_match<=0, and det_ch holds.
- **Counters.**
  - On a match, match_cnt[g] increments and saturates at 2^CNT_W-1 (no wrap).
  - clr_cnt[i] sets counter i to 0.
  - If clr_cnt[g] and a match on g occur in the same cycle, the clear wins and the counter becomes 0.
  - Clears on other channels proceed independently.
- **Reset.** While reset=1 at a clock edge:
  - All ctx are set to S0 and ptr to 0.
  - det_valid, det_ch and det_match are set to 0, and all match_cnt are set to 0.
  - in_ready still follows in_valid combinationally, but no transfer takes effect.
  - An in-progress prefix is discarded: after reset, a bit sequence of 0,1 on any channel does not match.

## Timing
- Throughput is one bit per cycle in total, across all channels.
- A channel with in_valid held high is granted at least once every NCH cycles.
- Latency: a bit consumed at edge N appears as det_valid/det_ch/det_match during cycle N+1. match_cnt reflects the match from edge N onward.
- in_bit is sampled only when the channel is granted. A requester holds in_bit stable while in_valid=1 and in_ready=0.
- Dropping in_valid without a grant is allowed and has no effect.
- ctx and ptr are updated on the same edge as the result register.

## Test plan
- **Single channel.** Channel 0 held valid with bits 1,0,1,0,1. Required: det_match=1 on the 3rd and 5th results, det_ch=0 throughout, match_cnt[0]=2.
- **Round robin.** All 4 channels held valid for 8 cycles. Required grant order 0,1,2,3,0,1,2,3. Then only channels 1 and 3 valid, starting with ptr=0. Required order 1,3,1,3.
- **Context isolation.** Interleave channel 0 bits 1,0,1 with channel 2 bits 0,1,1 in alternating cycles. Required: exactly one match, on channel 0; ctx[2] ends in S1; match_cnt[2]=0.
- **Saturation.** With CNT_W=2, drive channel 1 with 10101010101 (five matches). Required: match_cnt[1] reaches 3 and stays at 3.
- **Clear vs increment.** Channel 0 in S2; assert clr_cnt[0] in the same cycle as bit 1 is consumed. Required: det_match=1 and match_cnt[0]=0. Clearing channel 1 in the same cycle leaves channel 0's behaviour unchanged.
- **Reset mid-operation.** Channel 3 fed 1,0, then reset=1 for one cycle, then 1. Required:
  - No match.
  - All det outputs read 0 in the cycle after reset.
  - ptr=0, so a subsequent all-valid request grants channel 0 first.

Source files
------------

// File: rtl/seq_detect_scheduler.sv
// Round-robin shared "101" overlapping Mealy detector with per-channel saved context,
// a tagged registered match result and saturating per-channel match counters.
module seq_detect_scheduler #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned CNT_W = 8,
    localparam int unsigned CH_W = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH-1:0]       in_bit,
    output logic [NCH-1:0]       in_ready,
    input  logic [NCH-1:0]       clr_cnt,
    output logic                 det_valid,
    output logic [CH_W-1:0]      det_ch,
    output logic                 det_match,
    output logic [NCH*CNT_W-1:0] match_cnt
);

    typedef enum logic [1:0] {
        StS0 = 2'd0,
        StS1 = 2'd1,
        StS2 = 2'd2
    } ctx_e;

    ctx_e             ctx_q [NCH];
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [CH_W-1:0]  ptr_q, ptr_d;

    logic [CH_W-1:0]  idx;
    logic [CH_W-1:0]  grant;
    logic             found;
    ctx_e             cur_ctx, nxt_ctx;
    logic             gbit;
    logic             match;

    // Cyclic first-valid search starting at the priority pointer.
    always_comb begin
        idx      = '0;
        grant    = '0;
        found    = 1'b0;
        in_ready = '0;
        for (int k = 0; k < int'(NCH); k++) begin
            idx = CH_W'((32'(ptr_q) + 32'(k)) % NCH);
            if (!found && in_valid[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
        if (found) begin
            in_ready[grant] = 1'b1;
        end
    end

    always_comb begin
        cur_ctx = ctx_q[grant];
        gbit    = in_bit[grant];
        nxt_ctx = StS0;
        match   = 1'b0;
        unique case (cur_ctx)
            StS0: nxt_ctx = gbit ? StS1 : StS0;
            StS1: nxt_ctx = gbit ? StS1 : StS2;
            StS2: begin
                nxt_ctx = gbit ? StS1 : StS0;
                match   = gbit;
            end
            default: nxt_ctx = StS0;
        endcase
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = (grant == CH_W'(NCH - 1)) ? '0 : grant + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q     <= '0;
            det_valid <= 1'b0;
            det_ch    <= '0;
            det_match <= 1'b0;
            for (int i = 0; i < int'(NCH); i++) begin
                ctx_q[i] <= StS0;
                cnt_q[i] <= '0;
            end
        end else begin
            ptr_q     <= ptr_d;
            det_valid <= found;
            det_match <= found & match;
            if (found) begin
                det_ch        <= grant;
                ctx_q[grant]  <= nxt_ctx;
            end
            // A clear on a channel takes priority over a simultaneous increment.
            for (int i = 0; i < int'(NCH); i++) begin
                if (clr_cnt[i]) begin
                    cnt_q[i] <= '0;
                end else if (found && match && grant == CH_W'(i) &&
                             cnt_q[i] != {CNT_W{1'b1}}) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < int'(NCH); i++) begin : g_cnt_out
        assign match_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Directed bench for seq_detect_scheduler (NCH=4, CNT_W=2) with hand-computed expectations.
module tb_seq_detect_scheduler;

    localparam int NCH   = 4;
    localparam int CNT_W = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_bit;
    logic [NCH-1:0]       in_ready;
    logic [NCH-1:0]       clr_cnt;
    logic                 det_valid;
    logic [1:0]           det_ch;
    logic                 det_match;
    logic [NCH*CNT_W-1:0] match_cnt;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    seq_detect_scheduler #(
        .NCH   (NCH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_ready  (in_ready),
        .clr_cnt   (clr_cnt),
        .det_valid (det_valid),
        .det_ch    (det_ch),
        .det_match (det_match),
        .match_cnt (match_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [CNT_W-1:0] cnt(input int ch);
        return match_cnt[ch*CNT_W +: CNT_W];
    endfunction

    // Drive one cycle of inputs, check the grant before the edge and the result after it.
    task automatic step(input logic [3:0] v, input logic [3:0] b, input logic [3:0] clr,
                        input logic [3:0] exp_rdy, input logic exp_dv,
                        input logic [1:0] exp_ch, input logic exp_m);
        in_valid = v;
        in_bit   = b;
        clr_cnt  = clr;
        #1;
        check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        #1;
        check_eq("det_valid", 32'(det_valid), 32'(exp_dv));
        check_eq("det_ch", 32'(det_ch), 32'(exp_ch));
        check_eq("det_match", 32'(det_match), 32'(exp_m));
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = '0;
        in_bit   = '0;
        clr_cnt  = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    int sat_bit [11] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    int sat_m   [11] = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    int sat_c   [11] = '{0, 0, 1, 1, 2, 2, 3, 3, 3, 3, 3};

    initial begin
        reset    = 1'b1;
        in_valid = '0;
        in_bit   = '0;
        clr_cnt  = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("rst_det_valid", 32'(det_valid), 32'd0);
        check_eq("rst_det_ch", 32'(det_ch), 32'd0);
        check_eq("rst_det_match", 32'(det_match), 32'd0);
        check_eq("rst_match_cnt", 32'(match_cnt), 32'd0);

        // Single channel: 1,0,1,0,1 on channel 0.
        step(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0);
        step(4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0);
        step(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b1);
        step(4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0);
        step(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b1);
        check_eq("single_cnt0", 32'(cnt(0)), 32'd2);
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);

        // Round robin: all valid for 8 cycles, then only channels 1 and 3.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            step(4'b1111, 4'b0000, 4'b0000, 4'(1 << (k % 4)), 1'b1, 2'(k % 4), 1'b0);
        end
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd3, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(4'b1010, 4'b0000, 4'b0000, (k % 2 == 1) ? 4'b1000 : 4'b0010, 1'b1,
                 (k % 2 == 1) ? 2'd3 : 2'd1, 1'b0);
        end

        // Context isolation: ch0 1,0,1 interleaved with ch2 0,1,1.
        do_reset();
        step(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0);
        step(4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0);
        step(4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0);
        step(4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0);
        step(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b1);
        step(4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0);
        check_eq("iso_cnt0", 32'(cnt(0)), 32'd1);
        check_eq("iso_cnt2", 32'(cnt(2)), 32'd0);
        // ch2 should sit in S1, so 0,1 completes a match.
        step(4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0);
        step(4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b1);
        check_eq("iso_cnt2_after", 32'(cnt(2)), 32'd1);

        // Saturation: 10101010101 on channel 1 with 2-bit counters.
        do_reset();
        for (int k = 0; k < 11; k++) begin
            step(4'b0010, (sat_bit[k] != 0) ? 4'b0010 : 4'b0000, 4'b0000, 4'b0010, 1'b1,
                 2'd1, 1'(sat_m[k]));
            check_eq("sat_cnt1", 32'(cnt(1)), 32'(sat_c[k]));
        end

        // Clear versus increment on channel 0.
        do_reset();
        step(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0);
        step(4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0);
        step(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b1);
        check_eq("clr_pre_cnt0", 32'(cnt(0)), 32'd1);
        step(4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0);
        step(4'b0001, 4'b0001, 4'b0001, 4'b0001, 1'b1, 2'd0, 1'b1);
        check_eq("clr_win_cnt0", 32'(cnt(0)), 32'd0);
        step(4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0);
        step(4'b0001, 4'b0001, 4'b0010, 4'b0001, 1'b1, 2'd0, 1'b1);
        check_eq("clr_other_cnt0", 32'(cnt(0)), 32'd1);

        // Reset mid-operation: ch3 fed 1,0, ptr moved to 2, then reset.
        step(4'b1000, 4'b1000, 4'b0000, 4'b1000, 1'b1, 2'd3, 1'b0);
        step(4'b1000, 4'b0000, 4'b0000, 4'b1000, 1'b1, 2'd3, 1'b0);
        step(4'b0010, 4'b0000, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0);
        reset    = 1'b1;
        in_valid = 4'b1000;
        in_bit   = 4'b1000;
        clr_cnt  = 4'b0000;
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'b1000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("mid_det_valid", 32'(det_valid), 32'd0);
        check_eq("mid_det_ch", 32'(det_ch), 32'd0);
        check_eq("mid_det_match", 32'(det_match), 32'd0);
        check_eq("mid_match_cnt", 32'(match_cnt), 32'd0);
        for (int k = 0; k < 4; k++) begin
            step(4'b1111, 4'b1000, 4'b0000, 4'(1 << k), 1'b1, 2'(k), 1'b0);
        end
        check_eq("mid_cnt3", 32'(cnt(3)), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
